// File: rtl/cl_cmd_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : cl_cmd_serializer
//  Purpose  : Camera Link serial-control command encoder. Turns one
//             register-write request (bank, addr, data) into a 4-byte
//             UART 8N1 packet {hdr, addr, data, checksum} on txd.
//  Revision : 1.0  initial release
// ============================================================================
module cl_cmd_serializer #(
   parameter logic [7:0]  HDR_BASE = 8'hA0,
   parameter int          GAP_BITS = 1,
   parameter logic [15:0] MIN_DIV  = 16'd4
) (
   input  logic        clk_fix,
   input  logic        rst_fix,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_bank,
   input  logic [7:0]  cmd_addr,
   input  logic [7:0]  cmd_data,
   input  logic [15:0] baud_div,
   output logic        txd,
   output logic        busy,
   output logic        pkt_done
);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_start = 3'd1;
   localparam logic [2:0] c_st_data  = 3'd2;
   localparam logic [2:0] c_st_stop  = 3'd3;
   localparam logic [2:0] c_st_gap   = 3'd4;

   // Terminal value of the gap counter; unused when GAP_BITS is zero.
   localparam logic [2:0] c_gap_last = (GAP_BITS > 0) ? 3'(GAP_BITS - 1) : 3'd0;

   logic [2:0]  state_q,    state_d;
   logic [15:0] cnt_q,      cnt_d;
   logic [15:0] div_q,      div_d;
   logic [2:0]  bit_idx_q,  bit_idx_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [2:0]  gap_q,      gap_d;
   logic [7:0]  shreg_q,    shreg_d;
   logic [7:0]  addr_q,     addr_d;
   logic [7:0]  data_q,     data_d;
   logic [7:0]  chk_q,      chk_d;
   logic        pend_q,     pend_d;
   logic        pkt_done_q, pkt_done_d;
   logic        txd_q,      txd_d;

   logic        accept;
   logic        bit_end;
   logic        byte_end;
   logic [7:0]  hdr;
   logic [7:0]  next_byte;

   // txd is registered from the state, so the line lags the FSM by one
   // cycle. pend_q covers that lag at the end of a packet: the FSM is
   // already in IDLE but the last gap bit is still on the wire, and
   // pkt_done / cmd_ready are held back until it has gone out.
   assign cmd_ready = ~rst_fix & (state_q == c_st_idle) & ~pend_q;
   assign busy      = ~rst_fix & ((state_q != c_st_idle) | pend_q);
   assign pkt_done  = pkt_done_q;
   assign txd       = txd_q;

   assign accept  = cmd_valid & cmd_ready;
   assign bit_end = (cnt_q == (div_q - 16'd1));
   assign hdr     = HDR_BASE | ({6'd0, cmd_bank} + 8'd1);

   // Byte that follows the one currently indexed: addr, data, then checksum.
   always_comb begin
      next_byte = chk_q;
      case (byte_idx_q)
         2'd0:    next_byte = addr_q;
         2'd1:    next_byte = data_q;
         default: next_byte = chk_q;
      endcase
   end

   // Next-state logic: bit timing, bit/byte sequencing and request latching.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      gap_d      = gap_q;
      shreg_d    = shreg_q;
      addr_d     = addr_q;
      data_d     = data_q;
      chk_d      = chk_q;
      pend_d     = 1'b0;
      pkt_done_d = pend_q;
      byte_end   = 1'b0;

      case (state_q)
         c_st_idle: begin
            if (accept) begin
               addr_d     = cmd_addr;
               data_d     = cmd_data;
               chk_d      = hdr ^ cmd_addr ^ cmd_data;
               shreg_d    = hdr;
               div_d      = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
               cnt_d      = 16'd0;
               byte_idx_d = 2'd0;
               state_d    = c_st_start;
            end
         end
         c_st_start: begin
            if (bit_end) begin
               cnt_d     = 16'd0;
               bit_idx_d = 3'd0;
               state_d   = c_st_data;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         c_st_data: begin
            if (bit_end) begin
               cnt_d   = 16'd0;
               shreg_d = {1'b0, shreg_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = c_st_stop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         c_st_stop: begin
            if (bit_end) begin
               cnt_d = 16'd0;
               if (GAP_BITS > 0) begin
                  gap_d   = 3'd0;
                  state_d = c_st_gap;
               end else begin
                  byte_end = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         c_st_gap: begin
            if (bit_end) begin
               cnt_d = 16'd0;
               if (gap_q == c_gap_last) begin
                  byte_end = 1'b1;
               end else begin
                  gap_d = gap_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = c_st_idle;
      endcase

      // End of a byte: chain straight into the next start bit, or finish.
      if (byte_end) begin
         if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shreg_d    = next_byte;
            state_d    = c_st_start;
         end else begin
            pend_d  = 1'b1;
            state_d = c_st_idle;
         end
      end
   end

   // Line level for the state held during the current cycle.
   always_comb begin
      txd_d = 1'b1;
      case (state_q)
         c_st_start: txd_d = 1'b0;
         c_st_data:  txd_d = shreg_q[0];
         default:    txd_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset discards any packet in flight.
   always_ff @(posedge clk_fix) begin
      if (rst_fix) begin
         state_q    <= c_st_idle;
         cnt_q      <= 16'd0;
         div_q      <= MIN_DIV;
         bit_idx_q  <= 3'd0;
         byte_idx_q <= 2'd0;
         gap_q      <= 3'd0;
         shreg_q    <= 8'd0;
         addr_q     <= 8'd0;
         data_q     <= 8'd0;
         chk_q      <= 8'd0;
         pend_q     <= 1'b0;
         pkt_done_q <= 1'b0;
         txd_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         gap_q      <= gap_d;
         shreg_q    <= shreg_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         chk_q      <= chk_d;
         pend_q     <= pend_d;
         pkt_done_q <= pkt_done_d;
         txd_q      <= txd_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cl_cmd_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cl_cmd_serializer
//  Purpose  : Self-checking bench for cl_cmd_serializer. Expected line
//             waveform, handshake timing and decoded bytes come from an
//             arithmetic packet model built from the command fields.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cl_cmd_serializer;

   localparam int G     = 1;
   localparam int MIN_D = 4;

   logic        clk_fix = 1'b0;
   logic        rst_fix;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_bank;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_data;
   logic [15:0] baud_div;
   logic        txd;
   logic        busy;
   logic        pkt_done;

   int errs   = 0;
   int checks = 0;
   logic rec [0:2047];

   cl_cmd_serializer dut (
      .clk_fix   (clk_fix),
      .rst_fix   (rst_fix),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_bank  (cmd_bank),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .baud_div  (baud_div),
      .txd       (txd),
      .busy      (busy),
      .pkt_done  (pkt_done)
   );

   always #5 clk_fix = ~clk_fix;

   // Single comparison point for the whole bench.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Packet as four bytes, byte b at bits [8b+7:8b]: hdr, addr, data, chk.
   function automatic logic [31:0] make_pkt(input logic [1:0] bank, input logic [7:0] a, input logic [7:0] dt);
      logic [7:0] h;
      h = 8'hA0 | (8'(bank) + 8'd1);
      return {h ^ a ^ dt, dt, a, h};
   endfunction

   // Expected line level k cycles after the accept edge.
   function automatic logic exp_txd(input int k, input int d, input logic [31:0] pk);
      int j, per, b, r, bt;
      if (k < 1) return 1'b1;
      j   = k - 1;
      per = (10 + G) * d;
      if (j >= 4 * per) return 1'b1;
      b  = j / per;
      r  = j % per;
      bt = r / d;
      if (bt == 0) return 1'b0;
      if (bt <= 8) return pk[8*b + bt - 1];
      return 1'b1;
   endfunction

   // Present one request, then follow the packet cycle by cycle.
   task automatic send(input logic [1:0] bank, input logic [7:0] a, input logic [7:0] dt,
                       input logic [15:0] baud, input bit keep,
                       input int chg_k, input logic [15:0] baud2,
                       input int rst_k, output int waited);
      int d, per, p, n, mis_txd, mis_ctl, n_bad;
      logic [31:0] pk;
      logic [7:0]  dec;
      cmd_bank  = bank;
      cmd_addr  = a;
      cmd_data  = dt;
      baud_div  = baud;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 2000) begin
         @(negedge clk_fix);
         n++;
      end
      waited = n;
      if (!cmd_ready) begin
         check_eq("ready_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk_fix);
      #1;
      if (!keep) cmd_valid = 1'b0;
      cmd_bank = 2'($urandom);
      cmd_addr = 8'($urandom);
      cmd_data = 8'($urandom);
      d   = (int'(baud) < MIN_D) ? MIN_D : int'(baud);
      per = (10 + G) * d;
      p   = 4 * per;
      pk  = make_pkt(bank, a, dt);
      mis_txd = 0;
      mis_ctl = 0;
      for (int k = 0; k <= p + 1; k++) begin
         @(negedge clk_fix);
         if (k == chg_k) baud_div = baud2;
         rec[k] = txd;
         if (txd !== exp_txd(k, d, pk)) mis_txd++;
         if (pkt_done !== (k == p + 1)) mis_ctl++;
         if (busy !== (k <= p)) mis_ctl++;
         if (cmd_ready !== (k == p + 1)) mis_ctl++;
         if (k == rst_k) begin
            check_eq("rst_pre_wave", mis_txd, 0);
            rst_fix   = 1'b1;
            cmd_valid = 1'b0;
            @(negedge clk_fix);
            check_eq("rst_txd", txd, 1);
            check_eq("rst_ready", cmd_ready, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", pkt_done, 0);
            rst_fix = 1'b0;
            #1;
            check_eq("rst_ready_after", cmd_ready, 1);
            n_bad = 0;
            for (int i = 0; i < 2 * per; i++) begin
               @(negedge clk_fix);
               if (pkt_done !== 1'b0 || txd !== 1'b1) n_bad++;
            end
            check_eq("rst_quiet", n_bad, 0);
            return;
         end
      end
      check_eq("txd_wave", mis_txd, 0);
      check_eq("ctl_timing", mis_ctl, 0);
      for (int b = 0; b < 4; b++) begin
         for (int bt = 0; bt < 8; bt++) dec[bt] = rec[1 + b*per + (bt+1)*d + d/2];
         check_eq($sformatf("byte%0d", b), dec, pk[8*b +: 8]);
      end
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst_fix   = 1'b1;
      cmd_valid = 1'b0;
      cmd_bank  = 2'd0;
      cmd_addr  = 8'd0;
      cmd_data  = 8'd0;
      baud_div  = 16'd8;
      repeat (3) @(negedge clk_fix);
      check_eq("reset_txd", txd, 1);
      check_eq("reset_ready", cmd_ready, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", pkt_done, 0);
      rst_fix = 1'b0;
      #1;
      check_eq("ready_after_reset", cmd_ready, 1);

      // Basic packet, 8 clocks per bit.
      send(2'd0, 8'h12, 8'h34, 16'd8, 1'b0, -1, 16'd0, -1, w);
      // Divider below the minimum is clamped.
      send(2'd1, 8'h5A, 8'hC3, 16'd2, 1'b0, -1, 16'd0, -1, w);
      // Back-to-back with valid held high.
      send(2'd3, 8'hFF, 8'h00, 16'd8, 1'b1, -1, 16'd0, -1, w);
      send(2'd3, 8'hFF, 8'h00, 16'd8, 1'b1, -1, 16'd0, -1, w);
      check_eq("b2b_wait", w, 0);
      send(2'd2, 8'h80, 8'h01, 16'd4, 1'b0, -1, 16'd0, -1, w);
      check_eq("b2b_wait2", w, 0);
      // Reset during a data bit of the second byte, then a clean packet.
      send(2'd2, 8'hA5, 8'h3C, 16'd8, 1'b0, -1, 16'd0, 1 + 11*8 + 3*8, w);
      send(2'd1, 8'h77, 8'h88, 16'd5, 1'b0, -1, 16'd0, -1, w);
      // Divider change mid-packet applies only to the next packet.
      send(2'd1, 8'h55, 8'hAA, 16'd8, 1'b0, 50, 16'd16, -1, w);
      send(2'd0, 8'h0F, 8'hF0, 16'd16, 1'b0, -1, 16'd0, -1, w);

      // Randomized requests.
      for (int i = 0; i < 20; i++) begin
         send(2'($urandom), 8'($urandom), 8'($urandom),
              16'($urandom_range(0, 9)), 1'($urandom),
              int'($urandom_range(2, 150)), 16'($urandom_range(0, 20)), -1, w);
      end
      cmd_valid = 1'b0;
      @(negedge clk_fix);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cl_cmd_serializer.md
Name: cl_cmd_serializer

Overview:
- Host-side command encoder for the Camera Link serial control channel. It is the transmit counterpart of the on-camera serial receiver and register-bank decoder.
- Takes one register-write request (bank, address, data) and serializes it as a 4-byte UART 8N1 packet on a single-ended txd line. The LVDS output buffer is outside this block.
- Used in the loopback self-test path and by the bench to drive the camera's control port at a programmable baud rate.

Parameters:
- HDR_BASE, 8'hA0, header byte base; transmitted header = HDR_BASE | (cmd_bank + 1), giving 0xA1..0xA4.
- GAP_BITS, 1, extra idle-high bit periods appended after each stop bit; range 0..7.
- MIN_DIV, 16'd4, minimum clocks per bit; smaller baud_div values are clamped to this.

Ports:
- clk_fix  in  1  fixed system clock; all logic is on its rising edge.
- rst_fix  in  1  synchronous active-high reset.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  block can accept a request.
- cmd_bank  in  2  target register bank 0..3 (maps to rb1..rb4).
- cmd_addr  in  8  register address.
- cmd_data  in  8  register data.
- baud_div  in  16  clocks per bit period.
- txd  out  1  serial output; idles high, LSB first.
- busy  out  1  packet in progress.
- pkt_done  out  1  one-cycle pulse when a packet completes.

Behaviour:
- Reset values: txd=1, cmd_ready=0 during reset and 1 in the first cycle after it, busy=0, pkt_done=0. All counters clear; any in-flight packet is discarded.
- Reset mid-packet: txd=1 on the next edge. No pkt_done is generated. The state returns to IDLE.
- Accept: occurs on an edge where cmd_valid & cmd_ready.
  - bank, addr and data are latched, and the checksum = hdr ^ addr ^ data is computed.
  - div_q = max(baud_div, MIN_DIV) is latched.
  - Input changes after accept are ignored until the next accept.
- cmd_ready = 1 only in IDLE, and falls on the accept edge.
- busy = 1 from the accept edge until pkt_done.
- Byte order: hdr, addr, data, checksum.
- State machine:
  - IDLE: txd=1. Accept goes to START with byte_idx=0.
  - START: txd=0 for div_q cycles, then DATA.
  - DATA: txd = shreg[0], each bit held div_q cycles. Shift right after each bit; after bit 7 go to STOP.
  - STOP: txd=1 for div_q cycles. Then go to GAP if GAP_BITS>0; else NEXT.
  - GAP: txd=1 for GAP_BITS*div_q cycles, then NEXT.
  - NEXT: combinational decision with no extra cycle. If byte_idx<3, increment it, load the next byte and go to START. Otherwise assert pkt_done for one cycle and go to IDLE with cmd_ready=1.
- Timing:
  - First txd falling edge occurs on the edge after accept (latency 1).
  - Each byte occupies (10+GAP_BITS)*div_q cycles with no bubbles between bytes.
  - pkt_done is asserted on cycle accept + 1 + 4*(10+GAP_BITS)*div_q.
  - The next accept may occur on the same edge where pkt_done deasserts.
- Counters: 16-bit bit-period counter counting 0..div_q-1; 3-bit bit index; 2-bit byte index; 3-bit gap counter. No wrap beyond terminal counts.
- cmd_valid held while busy has no effect. A request is never lost or duplicated; the requester holds valid until ready.
- A baud_div change during a packet takes effect only at the next accept.

Test Plan:
- Reset, then bank=0, addr=0x12, data=0x34, baud_div=8 -> bytes A1,12,34,87 decoded by the bench UART model; each bit lasts 8 cycles; pkt_done 353 cycles after accept; cmd_ready returns to 1.
- baud_div=2 (below MIN_DIV) -> bit periods of 4 cycles; pkt_done at accept+177.
- Back-to-back requests with cmd_valid held high, bank=3, addr=0xFF, data=0x00 -> header A4, checksum 0x5B; second accept on the cycle after pkt_done; txd has no glitch between packets beyond the gap bits.
- rst_fix asserted during the DATA bit of the second byte -> txd=1 on the next edge; no pkt_done; cmd_ready=1 after reset; a fresh packet is transmitted correctly.
- baud_div changed from 8 to 16 mid-packet -> the current packet stays at 8 cycles per bit; the next packet uses 16.
- Loopback through the camera serial receiver with measured-baud enabled, 256 random writes -> every write reaches the matching register bank with the correct address and data, and there are zero checksum errors.
